srdrive_loop: RTL

SRDRIVE_LOOP -- requirements
Module: srdrive_loop

---
 rtl/srdrive_pkg.sv | 25 ++
 rtl/cmp_sync2.sv | 24 ++
 rtl/srdrive_loop.sv | 133 +++++++++++++
 3 files changed

// File: rtl/srdrive_pkg.sv
// Shared types and defaults for the SR-latch drive loop.
// The parameter legality helper keeps the rule in one place.
package srdrive_pkg;

  localparam int CNT_W      = 8;
  localparam int PERIOD_DEF = 100;
  localparam int SET_W_DEF  = 2;
  localparam int BLANK_DEF  = 8;
  localparam int MAXON_DEF  = 90;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_BLANK,
    ST_ON,
    ST_OFF
  } state_t;

  function automatic bit params_legal(input int per, input int set_w,
                                      input int blank, input int maxon);
    return (set_w > 0) && (set_w < blank) && (blank < maxon) &&
           (maxon < per) && (per <= 255);
  endfunction

endpackage

// File: rtl/cmp_sync2.sv
// Two-flop synchronizer for the asynchronous comparator trip.
module cmp_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/srdrive_loop.sv
// Peak-current style SR-latch drive loop: fixed period, set pulse, blanking,
// comparator or max-duty reset, and sticky latch-feedback fault detection.
//
// state | meaning
// IDLE  | disabled, latch held reset, cnt parked at 0
// SET   | set pulse driven, cnt 0..SET_W-1
// BLANK | leading-edge blanking, comparator ignored
// ON    | latch on, waiting for comparator trip or max duty
// OFF   | latch reset until the period wraps (or forever after a fault)
module srdrive_loop
  import srdrive_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int SET_W  = SET_W_DEF,
  parameter int BLANK  = BLANK_DEF,
  parameter int MAXON  = MAXON_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic en,
  input  logic cmp,
  input  logic q,
  output logic s,
  output logic r,
  output logic rb,
  output logic maxduty,
  output logic err
);

  if (!params_legal(PERIOD, SET_W, BLANK, MAXON)) begin : g_param_check
    $error("srdrive_loop: need 0 < SET_W < BLANK < MAXON < PERIOD <= 255");
  end

  localparam logic [CNT_W-1:0] L_PER_M1    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] L_SET_END   = CNT_W'(SET_W - 1);
  localparam logic [CNT_W-1:0] L_BLANK_END = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] L_MAXON_M1  = CNT_W'(MAXON - 1);

  // Supply/substrate pins only exist so the netlist matches the analog wrapper.
  logic w_unused_pins;
  assign w_unused_pins = CELV ^ CELG ^ SUB;

  logic w_cmp_s;

  cmp_sync2 u_cmp_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (cmp),
    .q    (w_cmp_s)
  );

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_off_prev;
  logic             r_s;
  logic             r_r;
  logic             r_rb;
  logic             r_maxduty;
  logic             r_err;
  logic             w_fb_fault;
  logic             w_err_nxt;
  logic             w_max_hit;
  logic             w_r_nxt;

  // The latch needs one cycle to fall after r rises, so OFF is only checked
  // from its second cycle.
  always_comb begin
    w_fb_fault  = ((r_state == ST_ON) && !q) ||
                  ((r_state == ST_OFF) && r_off_prev && q);
    w_err_nxt   = en && (r_err || w_fb_fault);
    w_max_hit   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == L_PER_M1) ? '0 : r_cnt + 1'b1;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (!r_err) w_state_nxt = ST_SET;
        end
        ST_SET:   if (r_cnt == L_SET_END)   w_state_nxt = ST_BLANK;
        ST_BLANK: if (r_cnt == L_BLANK_END) w_state_nxt = ST_ON;
        ST_ON: begin
          if (w_fb_fault || w_cmp_s) begin
            w_state_nxt = ST_OFF;
          end else if (r_cnt == L_MAXON_M1) begin
            w_state_nxt = ST_OFF;
            w_max_hit   = 1'b1;
          end
        end
        ST_OFF:   if ((r_cnt == L_PER_M1) && !w_err_nxt) w_state_nxt = ST_SET;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
    w_r_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_OFF);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_off_prev <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b1;
      r_rb       <= 1'b0;
      r_maxduty  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_off_prev <= (r_state == ST_OFF);
      r_s        <= (w_state_nxt == ST_SET);
      r_r        <= w_r_nxt;
      r_rb       <= !w_r_nxt;
      r_maxduty  <= w_max_hit;
      r_err      <= w_err_nxt;
    end
  end

  assign s       = r_s;
  assign r       = r_r;
  assign rb      = r_rb;
  assign maxduty = r_maxduty;
  assign err     = r_err;

endmodule
